flip_sequencer: RTL

Sequences one Othello move against the board store and the plot path. On a start pulse it validates the target cell, walks all 8 directions through the board RAM read port, writes every flanked disc to the mover's colour, and issues one handshaked redraw request per changed cell to the plot helper. It sits between the game control FSM (start/done/legal) and the board RAM plus plot helper, and is the only writer of both during a move.

---
 rtl/flip_sequencer.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/flip_sequencer.sv
// Othello move sequencer: validates the target cell, walks all eight directions
// through the board RAM, writes flanked discs and requests a redraw per changed cell.
module flip_sequencer (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [2:0] pos_x,
  input  logic [2:0] pos_y,
  input  logic       side,
  output logic [5:0] rd_addr,
  input  logic [1:0] rd_data,
  output logic       wr_en,
  output logic [5:0] wr_addr,
  output logic [1:0] wr_data,
  output logic       draw_req,
  output logic [2:0] draw_x,
  output logic [2:0] draw_y,
  output logic       draw_side,
  input  logic       draw_done,
  output logic       busy,
  output logic       done,
  output logic       legal,
  output logic [5:0] flip_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_ORIG_RD, S_ORIG_EV, S_STEP, S_WAIT, S_EVAL,
    S_FLIP_WR, S_FLIP_DRAW, S_NEXT_DIR, S_PLACE_WR, S_PLACE_DRAW, S_DONE
  } state_e;

  // Direction 0..7 = N, NE, E, SE, S, SW, W, NW with y growing downward.
  function automatic logic signed [3:0] dir_dx(input logic [2:0] dir);
    case (dir)
      3'd1, 3'd2, 3'd3: dir_dx = 4'sd1;
      3'd5, 3'd6, 3'd7: dir_dx = -4'sd1;
      default:          dir_dx = 4'sd0;
    endcase
  endfunction

  function automatic logic signed [3:0] dir_dy(input logic [2:0] dir);
    case (dir)
      3'd0, 3'd1, 3'd7: dir_dy = -4'sd1;
      3'd3, 3'd4, 3'd5: dir_dy = 4'sd1;
      default:          dir_dy = 4'sd0;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [2:0]         ox_q, ox_d, oy_q, oy_d;
  logic               side_q, side_d;
  logic [2:0]         dir_q, dir_d;
  logic [2:0]         run_q, run_d;
  logic signed [3:0]  px_q, px_d, py_q, py_d;
  logic [1:0]         cell_q, cell_d;
  logic [5:0]         flip_count_q, flip_count_d;
  logic               legal_q, legal_d;

  logic signed [3:0]  ox_s, oy_s, step_dx, step_dy, next_dx, next_dy;
  logic [2:0]         dir_next;
  logic [1:0]         own_code, opp_code;
  logic               in_board;

  assign ox_s     = {1'b0, ox_q};
  assign oy_s     = {1'b0, oy_q};
  assign step_dx  = dir_dx(dir_q);
  assign step_dy  = dir_dy(dir_q);
  assign dir_next = dir_q + 3'd1;
  assign next_dx  = dir_dx(dir_next);
  assign next_dy  = dir_dy(dir_next);
  assign own_code = side_q ? 2'b10 : 2'b01;
  assign opp_code = side_q ? 2'b01 : 2'b10;
  // Signed 4-bit probe: -1 and 8 both fall outside, so the walk never wraps.
  assign in_board = (px_q >= 4'sd0) && (px_q <= 4'sd7) &&
                    (py_q >= 4'sd0) && (py_q <= 4'sd7);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      ox_q         <= '0;
      oy_q         <= '0;
      side_q       <= 1'b0;
      dir_q        <= '0;
      run_q        <= '0;
      px_q         <= '0;
      py_q         <= '0;
      cell_q       <= '0;
      flip_count_q <= '0;
      legal_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      side_q       <= side_d;
      dir_q        <= dir_d;
      run_q        <= run_d;
      px_q         <= px_d;
      py_q         <= py_d;
      cell_q       <= cell_d;
      flip_count_q <= flip_count_d;
      legal_q      <= legal_d;
    end
  end

  // NOTE: every next-state variable takes its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    ox_d         = ox_q;
    oy_d         = oy_q;
    side_d       = side_q;
    dir_d        = dir_q;
    run_d        = run_q;
    px_d         = px_q;
    py_d         = py_q;
    cell_d       = cell_q;
    flip_count_d = flip_count_q;
    legal_d      = legal_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ox_d         = pos_x;
          oy_d         = pos_y;
          side_d       = side;
          flip_count_d = '0;
          legal_d      = 1'b0;
          state_d      = S_ORIG_RD;
        end
      end
      S_ORIG_RD: state_d = S_ORIG_EV;
      S_ORIG_EV: begin
        if (rd_data != 2'b00) begin
          state_d = S_DONE;
        end else begin
          dir_d   = '0;
          run_d   = '0;
          px_d    = ox_s + dir_dx(3'd0);
          py_d    = oy_s + dir_dy(3'd0);
          state_d = S_STEP;
        end
      end
      S_STEP: state_d = in_board ? S_WAIT : S_NEXT_DIR;
      S_WAIT: begin
        cell_d  = rd_data;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if (cell_q == opp_code) begin
          run_d   = run_q + 3'd1;
          px_d    = px_q + step_dx;
          py_d    = py_q + step_dy;
          state_d = S_STEP;
        end else if (cell_q == own_code && run_q != 3'd0) begin
          // Rewind to the first flanked cell and flip outward from the origin.
          px_d    = ox_s + step_dx;
          py_d    = oy_s + step_dy;
          state_d = S_FLIP_WR;
        end else begin
          state_d = S_NEXT_DIR;
        end
      end
      S_FLIP_WR: state_d = S_FLIP_DRAW;
      S_FLIP_DRAW: begin
        if (draw_done) begin
          flip_count_d = flip_count_q + 6'd1;
          run_d        = run_q - 3'd1;
          if (run_q == 3'd1) begin
            state_d = S_NEXT_DIR;
          end else begin
            px_d    = px_q + step_dx;
            py_d    = py_q + step_dy;
            state_d = S_FLIP_WR;
          end
        end
      end
      S_NEXT_DIR: begin
        if (dir_q == 3'd7) begin
          state_d = (flip_count_q == 6'd0) ? S_DONE : S_PLACE_WR;
        end else begin
          dir_d   = dir_next;
          run_d   = '0;
          px_d    = ox_s + next_dx;
          py_d    = oy_s + next_dy;
          state_d = S_STEP;
        end
      end
      S_PLACE_WR: state_d = S_PLACE_DRAW;
      S_PLACE_DRAW: begin
        if (draw_done) begin
          legal_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from registered state only; idle values are all zero.
  always_comb begin
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    draw_req  = 1'b0;
    draw_x    = '0;
    draw_y    = '0;
    draw_side = 1'b0;

    case (state_q)
      S_ORIG_RD: rd_addr = {oy_q, ox_q};
      S_STEP: begin
        if (in_board) rd_addr = {py_q[2:0], px_q[2:0]};
      end
      S_FLIP_WR: begin
        wr_en   = 1'b1;
        wr_addr = {py_q[2:0], px_q[2:0]};
        wr_data = own_code;
      end
      S_FLIP_DRAW: begin
        draw_req  = 1'b1;
        draw_x    = px_q[2:0];
        draw_y    = py_q[2:0];
        draw_side = side_q;
      end
      S_PLACE_WR: begin
        wr_en   = 1'b1;
        wr_addr = {oy_q, ox_q};
        wr_data = own_code;
      end
      S_PLACE_DRAW: begin
        draw_req  = 1'b1;
        draw_x    = ox_q;
        draw_y    = oy_q;
        draw_side = side_q;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign legal      = legal_q;
  assign flip_count = flip_count_q;

endmodule
